wb_spi_master_fifo: RTL
=======================

Name: wb_spi_master_fifo

Overview:
- Wishbone classic slave peripheral instantiated per SPI port inside wb_soc_top.
- Sits directly downstream of the SoC Wishbone bus and drives the SPI pins (sclk, cs_n, mosi, miso).
- Buffers TX and RX bytes in FIFOs and serialises them MSB-first with programmable clock divider, CPOL and CPHA.
- Raises an interrupt on TX-empty.

Parameters:
- FIFO_DEPTH, 4: entries in each of the TX and RX FIFOs; power of two, 2..16.
- DIV_W, 8: width of the clock-divider register.

Ports:
- wb_clk  in  1  system clock.
- wb_rst  in  1  reset; asynchronous, active-high.
- wb_adr_i  in  3  register index.
- wb_dat_i  in  32  write data; only bits [7:0] are used except in CTRL/DIV.
- wb_dat_o  out  32  read data.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_ack_o  out  1  acknowledge.
- o_spi_sclk  out  1  SPI clock.
- o_spi_cs_n  out  1  chip select, active-low.
- o_spi_mosi  out  1  serial out.
- i_spi_miso  in  1  serial in.
- o_irq  out  1  level interrupt.

Behaviour:
- Reset values:
  - Outputs: wb_ack_o=0, wb_dat_o=0, o_spi_sclk=0, o_spi_cs_n=1, o_spi_mosi=0, o_irq=0.
  - Registers and state: CTRL=0, DIV=0, both FIFOs empty, sticky flags=0, FSM=IDLE.
- Register map:
  - 0 CTRL RW: [0] en, [1] cpol, [2] cpha, [3] cs_hold, [4] irq_en.
  - 1 DIV RW: [DIV_W-1:0]; sclk half-period = DIV+1 wb_clk cycles.
  - 2 STATUS: RO except W1C bits.
    - [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] busy.
    - [5] rx_overrun, W1C, sticky.
    - [6] tx_drop, W1C, sticky.
  - 3 TXDATA WO: push [7:0]; reads return 0.
  - 4 RXDATA RO: pop; returns {24'b0, byte}; returns 0 and no pop when empty.
  - 5-7: reads return 0, writes ignored, still acked.
- Bus handshake:
  - wb_ack_o asserts the cycle after cyc&stb&!ack and is held exactly 1 cycle; one access per two cycles.
  - Write/pop side effects occur in the ack cycle.
  - wb_dat_o is valid in the ack cycle, 0 otherwise.
- Push to a full TX FIFO: data dropped, tx_drop set.
- FIFOs: pointer wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
  - Simultaneous push and pop on a full FIFO: both occur, count unchanged.
  - Simultaneous push and pop on an empty FIFO: read returns 0, push accepted.
- o_spi_sclk idles at cpol. Leading edge = first transition from idle; trailing edge = return to idle.
- FSM states:
  - IDLE: busy=0. If en & TX not empty -> LOAD.
  - LOAD (1 cycle):
    - Pop TX into shift register, assert cs_n=0, reset divider and bit counter (0..7).
    - If cpha=0, drive mosi=bit7 now.
    - -> SHIFT.
  - SHIFT: toggle sclk every DIV+1 cycles; 16 toggles per byte.
    - cpha=0: sample miso on leading edges, shift out the next bit on trailing edges.
    - cpha=1: drive the next bit on leading edges, sample on trailing edges.
    - After toggle 16 -> DONE.
  - DONE (1 cycle):
    - Push the received byte to RX. If RX is full and not popped this cycle: discard the byte and set rx_overrun.
    - If en & TX not empty -> LOAD, with cs_n held low (no deassert gap).
    - Else, if cs_hold=0, deassert cs_n=1; -> IDLE.
- cs_hold=1 keeps cs_n low in IDLE after the first byte, until cs_hold is cleared.
- en cleared mid-byte: the current byte completes, then the FSM returns to IDLE. TX contents are retained.
- CTRL.cpol/cpha/DIV writes while busy take effect at the next LOAD; they are latched at LOAD.
- o_irq = irq_en & tx_empty & !busy, registered (1-cycle latency).
- wb_rst asserted mid-transfer: immediate return to reset values (async), FIFOs flushed, cs_n=1 in the same cycle.

Test Plan:
- Reset, then read regs 0..7 -> all return 0 except STATUS=0x05 (tx_empty, rx_empty); o_spi_cs_n=1, o_spi_sclk=0.
- CTRL=0x01, DIV=1, write TXDATA=0xA5 with miso looped to mosi -> cs_n low 1 cycle after LOAD, 16 sclk toggles spaced 2 cycles, mosi sequence 1,0,1,0,0,1,0,1, RXDATA reads 0x000000A5, cs_n returns high, STATUS=0x05.
- Modes 1/2/3 (cpol/cpha = 01,10,11) with a slave model returning 0x3C -> RX=0x3C each; sclk idle level equals cpol before and after.
- Push 5 bytes with FIFO_DEPTH=4 while en=0 -> 5th dropped, STATUS[6]=1, tx_full=1; set en -> 4 back-to-back bytes, cs_n low continuously; write STATUS bit6=1 clears tx_drop.
- Send 5 bytes without popping RX -> rx_full=1, rx_overrun=1, RX holds the first 4 bytes in order.
- Assert wb_rst after sclk toggle 7 of a byte -> cs_n=1 and sclk=0 asynchronously; after release STATUS=0x05 and no further sclk activity.

Source files
------------

// File: rtl/wb_spi_master_fifo.sv
// Wishbone classic SPI master with TX/RX byte FIFOs.
// Bytes are shifted MSB-first with a programmable sclk half-period and
// selectable CPOL/CPHA. A level interrupt flags an empty TX FIFO while idle.
module wb_spi_master_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 8
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [2:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        o_spi_sclk,
    output logic        o_spi_cs_n,
    output logic        o_spi_mosi,
    input  logic        i_spi_miso,
    output logic        o_irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;

    // Bus and register state
    logic              ack_q, ack_d;
    logic [4:0]        ctrl_q, ctrl_d;       // {irq_en, cs_hold, cpha, cpol, en}
    logic [DIV_W-1:0]  div_q, div_d;
    logic              rx_ovr_q, rx_ovr_d;
    logic              tx_drop_q, tx_drop_d;
    logic              irq_q, irq_d;

    // FIFO state
    logic [7:0]        tx_mem_q [FIFO_DEPTH];
    logic [7:0]        tx_mem_d [FIFO_DEPTH];
    logic [7:0]        rx_mem_q [FIFO_DEPTH];
    logic [7:0]        rx_mem_d [FIFO_DEPTH];
    logic [AW-1:0]     tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [AW-1:0]     rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

    // SPI engine state
    state_t            state_q, state_d;
    logic              cpha_q, cpha_d;
    logic [DIV_W-1:0]  sdiv_q, sdiv_d;
    logic [DIV_W-1:0]  dcnt_q, dcnt_d;
    logic [4:0]        tog_q, tog_d;
    logic [7:0]        tx_sr_q, tx_sr_d;
    logic [7:0]        rx_sr_q, rx_sr_d;
    logic              sclk_q, sclk_d;
    logic              cs_n_q, cs_n_d;
    logic              mosi_q, mosi_d;

    // Handshake: the access completes in the single cycle wb_ack_o is high;
    // the master holds cyc/stb/adr/we/dat through that cycle, and all write
    // and pop side effects are registered at the end of it.
    logic bus_acc, bus_wr, bus_rd;
    logic tx_empty, tx_full, rx_empty, rx_full, busy, tick;
    logic tx_push_req, tx_push, tx_pop;
    logic rx_push_req, rx_push, rx_pop;
    logic [31:0] rd_data;
    logic unused_dat;

    assign bus_acc  = ack_q & wb_cyc_i & wb_stb_i;
    assign bus_wr   = bus_acc & wb_we_i;
    assign bus_rd   = bus_acc & ~wb_we_i;
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
    assign busy     = (state_q != ST_IDLE);
    assign tick     = (dcnt_q == sdiv_q);

    // A full FIFO still accepts a push when it is popped in the same cycle.
    assign tx_push_req = bus_wr && (wb_adr_i == 3'd3);
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign rx_pop      = bus_rd && (wb_adr_i == 3'd4) && !rx_empty;
    assign rx_push     = rx_push_req && (!rx_full || rx_pop);

    assign unused_dat = ^wb_dat_i;

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = bus_rd ? rd_data : 32'd0;
    assign o_spi_sclk = sclk_q;
    assign o_spi_cs_n = cs_n_q;
    assign o_spi_mosi = mosi_q;
    assign o_irq      = irq_q;

    // Read data multiplexer; RXDATA returns 0 when the FIFO is empty
    always_comb begin
        rd_data = 32'd0;
        case (wb_adr_i)
            3'd0: rd_data = {27'd0, ctrl_q};
            3'd1: rd_data = 32'(div_q);
            3'd2: rd_data = {25'd0, tx_drop_q, rx_ovr_q, busy,
                             rx_full, rx_empty, tx_full, tx_empty};
            3'd4: rd_data = rx_empty ? 32'd0 : {24'd0, rx_mem_q[rx_rp_q]};
            default: rd_data = 32'd0;
        endcase
    end

    // Register file, sticky flags, FIFO pointers and interrupt next-state
    always_comb begin
        ack_d     = wb_cyc_i & wb_stb_i & ~ack_q;
        ctrl_d    = ctrl_q;
        div_d     = div_q;
        tx_drop_d = tx_drop_q;
        rx_ovr_d  = rx_ovr_q;
        if (bus_wr && wb_adr_i == 3'd0) ctrl_d = wb_dat_i[4:0];
        if (bus_wr && wb_adr_i == 3'd1) div_d = wb_dat_i[DIV_W-1:0];
        if (bus_wr && wb_adr_i == 3'd2) begin
            if (wb_dat_i[5]) rx_ovr_d  = 1'b0;
            if (wb_dat_i[6]) tx_drop_d = 1'b0;
        end
        if (tx_push_req && !tx_push) tx_drop_d = 1'b1;
        if (rx_push_req && !rx_push) rx_ovr_d  = 1'b1;

        tx_mem_d = tx_mem_q;
        rx_mem_d = rx_mem_q;
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        if (tx_push) begin
            tx_mem_d[tx_wp_q] = wb_dat_i[7:0];
            tx_wp_d = tx_wp_q + AW'(1);
        end
        if (tx_pop) tx_rp_d = tx_rp_q + AW'(1);
        if (rx_push) begin
            rx_mem_d[rx_wp_q] = rx_sr_q;
            rx_wp_d = rx_wp_q + AW'(1);
        end
        if (rx_pop) rx_rp_d = rx_rp_q + AW'(1);
        tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);

        irq_d = ctrl_q[4] & tx_empty & ~busy;
    end

    // SPI engine next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ctrl_q[0] && !tx_empty) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (tick && tog_q == 5'd15) state_d = ST_DONE;
            ST_DONE:  state_d = (ctrl_q[0] && !tx_empty) ? ST_LOAD : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // SPI engine outputs and datapath: odd toggles are leading edges
    always_comb begin
        cpha_d      = cpha_q;
        sdiv_d      = sdiv_q;
        dcnt_d      = dcnt_q;
        tog_d       = tog_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        sclk_d      = sclk_q;
        cs_n_d      = cs_n_q;
        mosi_d      = mosi_q;
        tx_pop      = 1'b0;
        rx_push_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sclk_d = ctrl_q[1];
                if (!ctrl_q[3]) cs_n_d = 1'b1;
            end
            ST_LOAD: begin
                tx_pop  = 1'b1;
                cs_n_d  = 1'b0;
                dcnt_d  = '0;
                tog_d   = 5'd0;
                rx_sr_d = 8'd0;
                cpha_d  = ctrl_q[2];
                sdiv_d  = div_q;
                sclk_d  = ctrl_q[1];
                tx_sr_d = tx_mem_q[tx_rp_q];
                if (!ctrl_q[2]) begin
                    mosi_d  = tx_mem_q[tx_rp_q][7];
                    tx_sr_d = {tx_mem_q[tx_rp_q][6:0], 1'b0};
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    dcnt_d = '0;
                    sclk_d = ~sclk_q;
                    tog_d  = tog_q + 5'd1;
                    if (!tog_q[0]) begin
                        if (cpha_q) begin
                            mosi_d  = tx_sr_q[7];
                            tx_sr_d = {tx_sr_q[6:0], 1'b0};
                        end else begin
                            rx_sr_d = {rx_sr_q[6:0], i_spi_miso};
                        end
                    end else begin
                        if (cpha_q) begin
                            rx_sr_d = {rx_sr_q[6:0], i_spi_miso};
                        end else if (tog_q != 5'd15) begin
                            mosi_d  = tx_sr_q[7];
                            tx_sr_d = {tx_sr_q[6:0], 1'b0};
                        end
                    end
                end else begin
                    dcnt_d = dcnt_q + DIV_W'(1);
                end
            end
            ST_DONE: begin
                rx_push_req = 1'b1;
                if (state_d != ST_LOAD && !ctrl_q[3]) cs_n_d = 1'b1;
            end
            default: begin
                cs_n_d = 1'b1;
            end
        endcase
    end

    // State register for bus, FIFOs and SPI engine
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            ack_q     <= 1'b0;
            ctrl_q    <= '0;
            div_q     <= '0;
            rx_ovr_q  <= 1'b0;
            tx_drop_q <= 1'b0;
            irq_q     <= 1'b0;
            tx_mem_q  <= '{default: '0};
            rx_mem_q  <= '{default: '0};
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            state_q   <= ST_IDLE;
            cpha_q    <= 1'b0;
            sdiv_q    <= '0;
            dcnt_q    <= '0;
            tog_q     <= 5'd0;
            tx_sr_q   <= 8'd0;
            rx_sr_q   <= 8'd0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            ctrl_q    <= ctrl_d;
            div_q     <= div_d;
            rx_ovr_q  <= rx_ovr_d;
            tx_drop_q <= tx_drop_d;
            irq_q     <= irq_d;
            tx_mem_q  <= tx_mem_d;
            rx_mem_q  <= rx_mem_d;
            tx_wp_q   <= tx_wp_d;
            tx_rp_q   <= tx_rp_d;
            rx_wp_q   <= rx_wp_d;
            rx_rp_q   <= rx_rp_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            state_q   <= state_d;
            cpha_q    <= cpha_d;
            sdiv_q    <= sdiv_d;
            dcnt_q    <= dcnt_d;
            tog_q     <= tog_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
        end
    end

endmodule
